// File: rtl/boss_attack_engine.sv
// boss_attack_engine: boss HP/phase tracking and a projectile pool firing single or spread volleys
module boss_attack_engine #(
   parameter int NUM_PROJ   = 5,
   parameter int PROJ_SPEED = 4,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int BOSS_W     = 64,
   parameter int BOSS_H     = 48,
   parameter int HP_INIT    = 100,
   parameter int HIT_DAMAGE = 5
) (
   input  logic                     clk_master,
   input  logic                     rst,
   input  logic                     pulse_cycleStep,
   input  logic                     bossHit,
   input  logic [9:0]               bossX,
   input  logic [8:0]               bossY,
   input  logic [31:0]              delay,
   output logic [NUM_PROJ*10-1:0]   projX,
   output logic [NUM_PROJ*9-1:0]    projY,
   output logic [NUM_PROJ-1:0]      projActive,
   output logic [9:0]               bossHP,
   output logic                     phase,
   output logic                     bossShoot,
   output logic                     defeated
);
   localparam logic [9:0]         HP_RST  = 10'(HP_INIT);
   localparam logic [9:0]         HP_HALF = 10'(HP_INIT / 2);
   localparam logic [9:0]         DMG     = 10'(HIT_DAMAGE);
   localparam logic [9:0]         OFF_X   = 10'(BOSS_W / 2);
   localparam logic [8:0]         OFF_Y   = 9'(BOSS_H);
   localparam logic [10:0]        SPD_Y   = 11'(PROJ_SPEED);
   localparam logic signed [10:0] SPD_X   = 11'(PROJ_SPEED);
   localparam logic signed [10:0] LIM_X   = 11'(SCREEN_W);
   localparam logic [10:0]        LIM_Y   = 11'(SCREEN_H);

   typedef enum logic {RUN, DEAD} state_t;

   state_t              state_q, state_d;
   logic                hit_prev_q, hit_prev_d;
   logic                shoot_q, shoot_d;
   logic [9:0]          hp_q, hp_d;
   logic [31:0]         cnt_q, cnt_d, cnt_n, dly;
   logic [NUM_PROJ-1:0] act_q, act_d;
   logic [9:0]          px_q [NUM_PROJ];
   logic [9:0]          px_d [NUM_PROJ];
   logic [8:0]          py_q [NUM_PROJ];
   logic [8:0]          py_d [NUM_PROJ];
   logic [1:0]          dx_q [NUM_PROJ];
   logic [1:0]          dx_d [NUM_PROJ];
   logic [10:0]         ny [NUM_PROJ];
   logic signed [10:0]  nx [NUM_PROJ];
   logic signed [10:0]  dv [NUM_PROJ];
   logic                kill, step, fire;
   logic [1:0]          req, placed;

   assign phase      = hp_q <= HP_HALF;
   assign bossHP     = hp_q;
   assign bossShoot  = shoot_q;
   assign defeated   = state_q == DEAD;
   assign projActive = act_q;

   genvar g;
   for (g = 0; g < NUM_PROJ; g++) begin : g_pack
      assign projX[10*g +: 10] = px_q[g];
      assign projY[9*g +: 9]   = py_q[g];
   end

   // Next state: hit damage first, then projectile motion, volley counter and slot allocation
   always_comb begin
      hit_prev_d = bossHit;
      hp_d       = (state_q == RUN && bossHit && !hit_prev_q) ? ((hp_q > DMG) ? hp_q - DMG : '0) : hp_q;
      kill       = hp_d == '0;
      state_d    = kill ? DEAD : state_q;
      step       = pulse_cycleStep && state_q == RUN && !kill;
      act_d      = act_q;
      for (int i = 0; i < NUM_PROJ; i++) begin
         dv[i]   = (dx_q[i] == 2'b01) ? SPD_X : (dx_q[i] == 2'b11) ? -SPD_X : '0;
         nx[i]   = $signed({1'b0, px_q[i]}) + dv[i];
         ny[i]   = {2'b00, py_q[i]} + SPD_Y;
         px_d[i] = px_q[i];
         py_d[i] = py_q[i];
         dx_d[i] = dx_q[i];
         if (step && act_q[i]) begin
            if (ny[i] >= LIM_Y || nx[i][10] || nx[i] >= LIM_X) act_d[i] = 1'b0;
            else begin
               px_d[i] = nx[i][9:0];
               py_d[i] = ny[i][8:0];
            end
         end
      end
      cnt_n  = cnt_q + 32'd1;
      dly    = (delay == '0) ? 32'd1 : delay;
      fire   = step && cnt_n >= dly;
      cnt_d  = step ? (fire ? '0 : cnt_n) : cnt_q;
      req    = phase ? 2'd3 : 2'd1;
      placed = 2'd0;
      for (int i = 0; i < NUM_PROJ; i++) begin
         if (fire && !act_d[i] && placed < req) begin
            act_d[i] = 1'b1;
            px_d[i]  = bossX + OFF_X;
            py_d[i]  = bossY + OFF_Y;
            dx_d[i]  = phase ? placed - 2'd1 : 2'd0;
            placed   = placed + 2'd1;
         end
      end
      shoot_d = placed != 2'd0;
      if (kill) act_d = '0;
   end

   // State register with synchronous reset overriding every other input
   always_ff @(posedge clk_master) begin
      if (rst) begin
         state_q    <= RUN;
         hit_prev_q <= 1'b0;
         shoot_q    <= 1'b0;
         hp_q       <= HP_RST;
         cnt_q      <= '0;
         act_q      <= '0;
         px_q       <= '{default: '0};
         py_q       <= '{default: '0};
         dx_q       <= '{default: '0};
      end else begin
         state_q    <= state_d;
         hit_prev_q <= hit_prev_d;
         shoot_q    <= shoot_d;
         hp_q       <= hp_d;
         cnt_q      <= cnt_d;
         act_q      <= act_d;
         px_q       <= px_d;
         py_q       <= py_d;
         dx_q       <= dx_d;
      end
   end
endmodule

// File: tb/tb_boss_attack_engine.sv
// tb_boss_attack_engine: scoreboard-driven scenario tests for boss_attack_engine
module tb_boss_attack_engine;
   localparam int N = 5;

   logic             clk_master = 1'b0;
   logic             rst = 1'b1;
   logic             pulse_cycleStep = 1'b0;
   logic             bossHit = 1'b0;
   logic [9:0]       bossX = 10'd100;
   logic [8:0]       bossY = 9'd50;
   logic [31:0]      delay = 32'd2;
   logic [N*10-1:0]  projX;
   logic [N*9-1:0]   projY;
   logic [N-1:0]     projActive;
   logic [9:0]       bossHP;
   logic             phase, bossShoot, defeated;

   typedef struct {
      string       nm;
      logic [31:0] v;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;

   boss_attack_engine #(.NUM_PROJ(N)) dut (
      .clk_master(clk_master), .rst(rst), .pulse_cycleStep(pulse_cycleStep), .bossHit(bossHit),
      .bossX(bossX), .bossY(bossY), .delay(delay), .projX(projX), .projY(projY),
      .projActive(projActive), .bossHP(bossHP), .phase(phase), .bossShoot(bossShoot), .defeated(defeated)
   );

   always #5 clk_master = ~clk_master;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [9:0] xs(int i);
      return projX[10*i +: 10];
   endfunction

   function automatic logic [8:0] ys(int i);
      return projY[9*i +: 9];
   endfunction

   task automatic do_reset;
      @(negedge clk_master);
      rst = 1'b1; pulse_cycleStep = 1'b0; bossHit = 1'b0;
      @(negedge clk_master);
      rst = 1'b0;
   endtask

   task automatic step;
      @(negedge clk_master);
      pulse_cycleStep = 1'b1;
      @(negedge clk_master);
      pulse_cycleStep = 1'b0;
   endtask

   task automatic hit;
      @(negedge clk_master);
      bossHit = 1'b1;
      @(negedge clk_master);
      bossHit = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      sb.push_back('{"reset hp", 32'd100});
      sb.push_back('{"reset flags", 32'd0});
      sb.push_back('{"reset act", 32'd0});
      sb.push_back('{"reset xy", 32'd0});
      e = sb.pop_front(); n_cmp++;
      if (bossHP !== e.v[9:0]) begin n_err++; $display("FAIL %s: got %0d want %0d", e.nm, bossHP, e.v); end
      e = sb.pop_front(); n_cmp++;
      if ({phase, bossShoot, defeated} !== e.v[2:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, {phase, bossShoot, defeated}, e.v[2:0]); end
      e = sb.pop_front(); n_cmp++;
      if (projActive !== e.v[4:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, projActive, e.v[4:0]); end
      e = sb.pop_front(); n_cmp++;
      if ((|projX || |projY) !== e.v[0]) begin n_err++; $display("FAIL %s: got %h/%h want 0", e.nm, projX, projY); end
   endtask

   task automatic test_single_volley;
      do_reset;
      delay = 32'd2; bossX = 10'd100; bossY = 9'd50;
      for (int k = 1; k <= 10; k++) begin
         sb.push_back('{$sformatf("single shoot step %0d", k), 32'(k % 2 == 0)});
         if (k == 2) sb.push_back('{"single spawn xy", 32'({10'd132, 9'd98})});
         if (k == 3) sb.push_back('{"single moved y", 32'd102});
         step;
         e = sb.pop_front(); n_cmp++;
         if (bossShoot !== e.v[0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, bossShoot, e.v[0]); end
         if (k == 2) begin
            e = sb.pop_front(); n_cmp++;
            if ({xs(0), ys(0)} !== e.v[18:0]) begin n_err++; $display("FAIL %s: got (%0d,%0d) want (132,98)", e.nm, xs(0), ys(0)); end
         end
         if (k == 3) begin
            e = sb.pop_front(); n_cmp++;
            if (ys(0) !== e.v[8:0]) begin n_err++; $display("FAIL %s: got %0d want %0d", e.nm, ys(0), e.v); end
         end
      end
      sb.push_back('{"single pulse width/act", 32'({1'b0, 5'b11111})});
      @(negedge clk_master);
      e = sb.pop_front(); n_cmp++;
      if ({bossShoot, projActive} !== e.v[5:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, {bossShoot, projActive}, e.v[5:0]); end
   endtask

   task automatic test_fill_exit;
      logic [31:0] a;
      do_reset;
      delay = 32'd1; bossX = 10'd100; bossY = 9'd50;
      for (int s = 1; s <= 97; s++) begin
         if (s == 97) delay = 32'd1000;
         a = (s <= 5) ? (32'd1 << s) - 32'd1 : (s == 97) ? 32'h1e : 32'h1f;
         sb.push_back('{$sformatf("fill shoot/act step %0d", s), 32'({s <= 5, a[4:0]})});
         if (s == 96) sb.push_back('{"fill slot0 y before exit", 32'd478});
         step;
         e = sb.pop_front(); n_cmp++;
         if ({bossShoot, projActive} !== e.v[5:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, {bossShoot, projActive}, e.v[5:0]); end
         if (s == 96) begin
            e = sb.pop_front(); n_cmp++;
            if (ys(0) !== e.v[8:0]) begin n_err++; $display("FAIL %s: got %0d want %0d", e.nm, ys(0), e.v); end
         end
      end
   endtask

   task automatic test_spread;
      do_reset;
      delay = 32'd1000; bossX = 10'd100; bossY = 9'd50;
      for (int h = 1; h <= 10; h++) begin
         sb.push_back('{$sformatf("spread phase/hp hit %0d", h), 32'({(100 - 5 * h) <= 50, 10'(100 - 5 * h)})});
         hit;
         e = sb.pop_front(); n_cmp++;
         if ({phase, bossHP} !== e.v[10:0]) begin n_err++; $display("FAIL %s: got %b/%0d want %b/%0d", e.nm, phase, bossHP, e.v[10], e.v[9:0]); end
      end
      delay = 32'd1;
      sb.push_back('{"spread volley shoot/act", 32'({1'b1, 5'b00111})});
      step;
      e = sb.pop_front(); n_cmp++;
      if ({bossShoot, projActive} !== e.v[5:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, {bossShoot, projActive}, e.v[5:0]); end
      delay = 32'd1000;
      sb.push_back('{"spread moved x", 32'({10'd128, 10'd132, 10'd136})});
      sb.push_back('{"spread moved y", 32'd102});
      step;
      e = sb.pop_front(); n_cmp++;
      if ({xs(0), xs(1), xs(2)} !== e.v[29:0]) begin n_err++; $display("FAIL %s: got %0d,%0d,%0d want 128,132,136", e.nm, xs(0), xs(1), xs(2)); end
      e = sb.pop_front(); n_cmp++;
      if (ys(0) !== e.v[8:0]) begin n_err++; $display("FAIL %s: got %0d want %0d", e.nm, ys(0), e.v); end
   endtask

   task automatic test_hit_hold;
      do_reset;
      sb.push_back('{"held hit hp", 32'd95});
      @(negedge clk_master);
      bossHit = 1'b1;
      repeat (20) @(negedge clk_master);
      bossHit = 1'b0;
      e = sb.pop_front(); n_cmp++;
      if (bossHP !== e.v[9:0]) begin n_err++; $display("FAIL %s: got %0d want %0d", e.nm, bossHP, e.v); end
      sb.push_back('{"rearmed hit hp", 32'd90});
      hit;
      e = sb.pop_front(); n_cmp++;
      if (bossHP !== e.v[9:0]) begin n_err++; $display("FAIL %s: got %0d want %0d", e.nm, bossHP, e.v); end
   endtask

   task automatic test_x_bounds;
      do_reset;
      repeat (10) hit;
      bossX = 10'd600; bossY = 9'd50; delay = 32'd1;
      step;
      delay = 32'd1000;
      sb.push_back('{"right edge act/x", 32'({5'b00111, 10'd628, 10'd636})});
      step;
      e = sb.pop_front(); n_cmp++;
      if ({projActive, xs(0), xs(2)} !== e.v[24:0]) begin n_err++; $display("FAIL %s: got %b %0d %0d want %b 628 636", e.nm, projActive, xs(0), xs(2), e.v[24:20]); end
      sb.push_back('{"right edge clear act", 32'b00011});
      step;
      e = sb.pop_front(); n_cmp++;
      if (projActive !== e.v[4:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, projActive, e.v[4:0]); end
      do_reset;
      repeat (10) hit;
      bossX = 10'd0; delay = 32'd1;
      step;
      delay = 32'd1000;
      sb.push_back('{"left edge act/x0", 32'({5'b00111, 10'd0})});
      repeat (8) step;
      e = sb.pop_front(); n_cmp++;
      if ({projActive, xs(0)} !== e.v[14:0]) begin n_err++; $display("FAIL %s: got %b %0d want %b 0", e.nm, projActive, xs(0), e.v[14:10]); end
      sb.push_back('{"left edge underflow act", 32'b00110});
      step;
      e = sb.pop_front(); n_cmp++;
      if (projActive !== e.v[4:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, projActive, e.v[4:0]); end
   endtask

   task automatic test_defeat;
      do_reset;
      delay = 32'd1; bossX = 10'd100; bossY = 9'd50;
      step;
      step;
      sb.push_back('{"defeat pre act", 32'b00011});
      e = sb.pop_front(); n_cmp++;
      if (projActive !== e.v[4:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, projActive, e.v[4:0]); end
      repeat (19) hit;
      sb.push_back('{"defeat pre hp", 32'd5});
      e = sb.pop_front(); n_cmp++;
      if (bossHP !== e.v[9:0]) begin n_err++; $display("FAIL %s: got %0d want %0d", e.nm, bossHP, e.v); end
      sb.push_back('{"defeat kill cycle", 32'({10'd0, 1'b0, 1'b1, 5'b0})});
      sb.push_back('{"defeat next cycle", 32'({10'd0, 1'b0, 1'b1, 5'b0})});
      @(negedge clk_master);
      bossHit = 1'b1; pulse_cycleStep = 1'b1;
      @(negedge clk_master);
      bossHit = 1'b0; pulse_cycleStep = 1'b0;
      e = sb.pop_front(); n_cmp++;
      if ({bossHP, bossShoot, defeated, projActive} !== e.v[16:0]) begin n_err++; $display("FAIL %s: got hp=%0d shoot=%b def=%b act=%b", e.nm, bossHP, bossShoot, defeated, projActive); end
      @(negedge clk_master);
      e = sb.pop_front(); n_cmp++;
      if ({bossHP, bossShoot, defeated, projActive} !== e.v[16:0]) begin n_err++; $display("FAIL %s: got hp=%0d shoot=%b def=%b act=%b", e.nm, bossHP, bossShoot, defeated, projActive); end
      for (int k = 0; k < 3; k++) begin
         sb.push_back('{$sformatf("dead ignores inputs %0d", k), 32'({10'd0, 1'b0, 1'b1, 5'b0})});
         step;
         hit;
         e = sb.pop_front(); n_cmp++;
         if ({bossHP, bossShoot, defeated, projActive} !== e.v[16:0]) begin n_err++; $display("FAIL %s: got hp=%0d shoot=%b def=%b act=%b", e.nm, bossHP, bossShoot, defeated, projActive); end
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      delay = 32'd1; bossX = 10'd100; bossY = 9'd50;
      repeat (3) hit;
      repeat (4) step;
      sb.push_back('{"mid pre hp/act", 32'({10'd85, 5'b01111})});
      e = sb.pop_front(); n_cmp++;
      if ({bossHP, projActive} !== e.v[14:0]) begin n_err++; $display("FAIL %s: got %0d/%b want 85/01111", e.nm, bossHP, projActive); end
      sb.push_back('{"mid reset outputs", 32'({10'd100, 1'b0, 1'b0, 1'b0, 5'b0})});
      sb.push_back('{"mid reset xy", 32'd0});
      @(negedge clk_master);
      rst = 1'b1; pulse_cycleStep = 1'b1; bossHit = 1'b1;
      @(negedge clk_master);
      rst = 1'b0; pulse_cycleStep = 1'b0; bossHit = 1'b0;
      e = sb.pop_front(); n_cmp++;
      if ({bossHP, phase, bossShoot, defeated, projActive} !== e.v[17:0]) begin n_err++; $display("FAIL %s: got hp=%0d ph=%b sh=%b def=%b act=%b", e.nm, bossHP, phase, bossShoot, defeated, projActive); end
      e = sb.pop_front(); n_cmp++;
      if ((|projX || |projY) !== e.v[0]) begin n_err++; $display("FAIL %s: got %h/%h want 0", e.nm, projX, projY); end
   endtask

   task automatic test_delay_zero;
      do_reset;
      delay = 32'd0;
      for (int s = 1; s <= 3; s++) begin
         sb.push_back('{$sformatf("delay0 shoot/act step %0d", s), 32'({1'b1, 5'((1 << s) - 1)})});
         step;
         e = sb.pop_front(); n_cmp++;
         if ({bossShoot, projActive} !== e.v[5:0]) begin n_err++; $display("FAIL %s: got %b want %b", e.nm, {bossShoot, projActive}, e.v[5:0]); end
      end
   endtask

   initial begin
      test_reset;
      test_single_volley;
      test_fill_exit;
      test_spread;
      test_hit_hold;
      test_x_bounds;
      test_defeat;
      test_reset_mid;
      test_delay_zero;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
